mdu_unit: RTL



---
 rtl/mdu_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// mult/multu/div/divu run for an exact latency; mthi/mtlo are single-cycle;
// mfhi/mflo are a combinational read.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu (ops 9-12).
module mdu_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0]             op_q, op_d;

  logic                   accept, is_mul, is_div;
  logic                   sgn, neg_a, neg_b, q_is_div, q_is_madd, q_is_msub;
  logic [WIDTH-1:0]       mag_a, mag_b, q_mag, r_mag, quo, rem;
  logic [2*WIDTH-1:0]     ext_a, ext_b, prod, mul_res;

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign accept = start & ~flush & ~busy;

  // Read port for mfhi/mflo, straight from the current registers.
  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI)      rd_data = hi_q;
    else if (op == OP_MFLO) rd_data = lo_q;
  end

  // Decode the incoming op into multiply-class and divide-class.
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  // Arithmetic on the latched operands; sampled into HI/LO on the final edge.
  // Division works on magnitudes so min/-1 falls out naturally (q = 2^(W-1)).
  always_comb begin
    sgn       = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
    q_is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    q_is_madd = (op_q == OP_MADD) || (op_q == OP_MADDU);
    q_is_msub = (op_q == OP_MSUB) || (op_q == OP_MSUBU);
    ext_a     = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    ext_b     = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod      = ext_a * ext_b;
    mul_res   = prod;
    if (q_is_madd)      mul_res = {hi_q, lo_q} + prod;
    else if (q_is_msub) mul_res = {hi_q, lo_q} - prod;
    neg_a     = sgn & a_q[WIDTH-1];
    neg_b     = sgn & b_q[WIDTH-1];
    mag_a     = neg_a ? -a_q : a_q;
    mag_b     = neg_b ? -b_q : b_q;
    q_mag     = (mag_b != '0) ? (mag_a / mag_b) : '0;
    r_mag     = (mag_b != '0) ? (mag_a % mag_b) : '0;
    quo       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem       = neg_a ? -r_mag : r_mag;
  end

  // Next-state logic: accept in IDLE, count down in BUSY, write on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul || is_div) begin
            a_d     = src_a;
            b_d     = src_b;
            op_d    = op;
            cnt_d   = is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            state_d = BUSY;
          end else if (op == OP_MTHI) begin
            hi_d = src_a;
          end else if (op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (q_is_div) begin
            // Divide by zero leaves HI/LO untouched.
            if (b_q != '0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
